// File: rtl/arrow_pkg.sv
// Shared constants and FSM encoding for the arrow-board lamp serializer.
package arrow_pkg;
    localparam int LAMP_W  = 16;
    localparam int DIV_MIN = 1;
    localparam int DIV_MAX = 255;
    localparam int HCNT_W  = 8;
    localparam int BCNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;
endpackage

// File: rtl/shift_tick_gen.sv
// Half-period tick: one-cycle pulse every DIV cycles while enabled.
// Latency: first tick DIV cycles after enable rises; counter held at 0 while disabled.
// Backpressure: none, free-running while enable is high.
module shift_tick_gen
    import arrow_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    logic [HCNT_W-1:0] r_cnt;
    logic              w_wrap;

    assign w_wrap = (r_cnt == HCNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + HCNT_W'(1);
        end
    end

    assign tick = enable && w_wrap;

endmodule

// File: rtl/lamp_shift_out.sv
// Serializes a 16-bit lamp word MSB first onto sclk/sdata, then strobes latch.
// Latency: 33*DIV cycles from accept edge to the done cycle; back-to-back accept in done cycle.
// Backpressure: load_ready low for the whole transfer; load_valid while busy is ignored.
module lamp_shift_out
    import arrow_pkg::*;
#(
    parameter int DIV    = 2,
    parameter int LAMP_W = arrow_pkg::LAMP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LAMP_W-1:0] lamps,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              sclk,
    output logic              sdata,
    output logic              latch,
    output logic              busy,
    output logic              done
);

    localparam int DIV_C = (DIV < DIV_MIN) ? DIV_MIN : ((DIV > DIV_MAX) ? DIV_MAX : DIV);

    state_t              r_state, w_state_nxt;
    logic [LAMP_W-1:0]   r_sr, w_sr_nxt;
    logic [BCNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_sdata, w_sdata_nxt;
    logic                r_latch, w_latch_nxt;
    logic                r_done, w_done_nxt;
    logic                r_busy, r_load_ready;
    logic                w_tick_en, w_tick;

    assign w_tick_en = (r_state != IDLE);

    shift_tick_gen #(
        .DIV (DIV_C)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_tick_en),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sclk_nxt    = r_sclk;
        w_sdata_nxt   = r_sdata;
        w_latch_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_state_nxt   = SHIFT;
                    w_sr_nxt      = lamps;
                    w_bit_cnt_nxt = '0;
                    w_sclk_nxt    = 1'b0;
                    w_sdata_nxt   = lamps[LAMP_W-1];
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // Next bit goes out on the falling edge so it is settled before the next rise.
                        w_sclk_nxt    = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
                        w_sr_nxt      = {r_sr[LAMP_W-2:0], r_sr[LAMP_W-1]};
                        w_sdata_nxt   = r_sr[LAMP_W-2];
                        if (r_bit_cnt == '1) begin
                            w_state_nxt = LATCH;
                            w_sdata_nxt = 1'b0;
                            w_latch_nxt = 1'b1;
                        end
                    end
                end
            end
            LATCH: begin
                w_latch_nxt = 1'b1;
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_latch_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_latch      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_sclk       <= w_sclk_nxt;
            r_sdata      <= w_sdata_nxt;
            r_latch      <= w_latch_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_load_ready <= (w_state_nxt == IDLE);
        end
    end

    assign load_ready = r_load_ready;
    assign busy       = r_busy;
    assign sclk       = r_sclk;
    assign sdata      = r_sdata;
    assign latch      = r_latch;
    assign done       = r_done;

endmodule

// File: tb/tb_lamp_shift_out.sv
// Bench for lamp_shift_out: four instances (DIV 1, 2, 3, 255) with an external shift/storage
// register model per instance; expected words are queued at accept and compared at latch.
module tb_lamp_shift_out;

    function automatic int div_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 255;
        endcase
    endfunction

    logic        clk;
    logic [3:0]  rst_n, load_valid, load_ready, sclk, sdata, latch, busy, done;
    logic [15:0] lamps [4];

    logic [15:0] exp_q [4][$];
    int          last_done [4];
    int          prev_done [4];
    int          acc_gap   [4];
    int          dbl_err   [4];
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached after %0d tests, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = div_of(g);

        lamp_shift_out #(
            .DIV    (D),
            .LAMP_W (16)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .lamps      (lamps[g]),
            .load_valid (load_valid[g]),
            .load_ready (load_ready[g]),
            .sclk       (sclk[g]),
            .sdata      (sdata[g]),
            .latch      (latch[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );

        // External 16-bit chain model plus timing bookkeeping, sampled mid-cycle.
        initial begin : mon
            logic [15:0] mdl;
            logic [15:0] want;
            logic        p_sclk, p_sdata, p_latch, p_busy, p_done;
            int          rises, phase_len, phase_err, hs_err, lat_len, lat_err, lat_cnt, rdy_err, t_acc;
            mdl = '0; p_sclk = 0; p_sdata = 0; p_latch = 0; p_busy = 0; p_done = 0;
            rises = 0; phase_len = 0; phase_err = 0; hs_err = 0;
            lat_len = 0; lat_err = 0; lat_cnt = 0; rdy_err = 0; t_acc = 0;
            forever begin
                @(negedge clk);
                if (rst_n[g] !== 1'b1) begin
                    mdl = '0; p_sclk = 0; p_sdata = 0; p_latch = 0; p_busy = 0; p_done = 0;
                    rises = 0; phase_len = 0; lat_cnt = 0; lat_len = 0; rdy_err = 0;
                end else begin
                    if (busy[g] && !p_busy) begin
                        t_acc      = cyc;
                        acc_gap[g] = cyc - last_done[g];
                        mdl = '0; rises = 0; phase_len = 0; phase_err = 0; hs_err = 0;
                        lat_len = 0; lat_err = 0; lat_cnt = 0; rdy_err = 0;
                    end
                    if (load_ready[g] === busy[g]) rdy_err++;
                    if (busy[g] && !latch[g]) begin
                        if (sclk[g] != p_sclk) begin
                            if (phase_len != D) phase_err++;
                            phase_len = 1;
                        end else begin
                            phase_len++;
                        end
                        if (sclk[g] && !p_sclk) begin
                            mdl = {mdl[14:0], sdata[g]};
                            rises++;
                        end
                        if (sclk[g] && (sdata[g] != p_sdata)) hs_err++;
                    end
                    if (latch[g]) begin
                        if (!p_latch) begin
                            if (phase_len != D) phase_err++;
                            lat_cnt++;
                            if (exp_q[g].size() == 0) begin
                                chk("word_unexpected", 32'(mdl), 32'hFFFF_FFFF);
                            end else begin
                                want = exp_q[g].pop_front();
                                chk("latched_word", 32'(mdl), 32'(want));
                            end
                            chk("sclk_rises", rises, 16);
                            chk("latch_time", cyc - t_acc, 32 * D);
                            chk("phase_len_err", phase_err, 0);
                            chk("sdata_change_high", hs_err, 0);
                        end
                        lat_len++;
                        if (sclk[g] || sdata[g] || !busy[g]) lat_err++;
                    end
                    if (done[g]) begin
                        chk("done_time", cyc - t_acc, 33 * D);
                        chk("latch_len", lat_len, D);
                        chk("latch_pulses", lat_cnt, 1);
                        chk("latch_phase_err", lat_err, 0);
                        chk("ready_vs_busy", rdy_err, 0);
                        chk("done_outputs", {29'd0, latch[g], load_ready[g], busy[g]}, 32'b010);
                        if (p_done) dbl_err[g]++;
                        prev_done[g] = last_done[g];
                        last_done[g] = cyc;
                    end
                    p_sclk  = sclk[g];
                    p_sdata = sdata[g];
                    p_latch = latch[g];
                    p_busy  = busy[g];
                    p_done  = done[g];
                end
            end
        end
    end

    // All driver tasks start and end just after a falling edge.
    task automatic send(input int i, input logic [15:0] w);
        int n = 0;
        while (load_ready[i] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(load_ready[i]), 32'd1);
        lamps[i]      = w;
        load_valid[i] = 1'b1;
        exp_q[i].push_back(w);
        @(negedge clk);
        load_valid[i] = 1'b0;
        lamps[i]      = 16'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((exp_q[i].size() != 0 || load_ready[i] !== 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", exp_q[i].size(), 0);
    endtask

    task automatic stream(input int k, input int count);
        for (int n = 0; n < count; n++) begin
            send(k, 16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_idle(k);
    endtask

    initial begin
        int n;
        int rdy_bad;
        int cnt [3];
        rst_n      = '0;
        load_valid = '0;
        for (int i = 0; i < 4; i++) lamps[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("reset_outputs", {26'd0, sclk[i], sdata[i], latch[i], done[i], busy[i], load_ready[i]}, 32'h1);

        // DIV=2: accept on the very first edge out of reset.
        rst_n         = '1;
        lamps[1]      = 16'hA5C3;
        load_valid[1] = 1'b1;
        exp_q[1].push_back(16'hA5C3);
        @(negedge clk);
        load_valid[1] = 1'b0;
        lamps[1]      = 16'h0F0F;
        chk("first_accept", 32'(busy[1]), 32'd1);
        wait_idle(1);

        // DIV=2: hold valid and scramble lamps during the transfer.
        lamps[1]      = 16'hFFFF;
        load_valid[1] = 1'b1;
        exp_q[1].push_back(16'hFFFF);
        @(negedge clk);
        lamps[1] = 16'h0000;
        chk("hold_accept", 32'(busy[1]), 32'd1);
        n = 0;
        rdy_bad = 0;
        while (done[1] !== 1'b1 && n < 200) begin
            if (load_ready[1] !== 1'b0) rdy_bad++;
            @(negedge clk);
            n++;
        end
        chk("hold_ready_low", rdy_bad, 0);
        chk("hold_done_seen", 32'(done[1]), 32'd1);
        exp_q[1].push_back(16'h0000);
        @(negedge clk);
        load_valid[1] = 1'b0;
        chk("hold_reaccept", 32'(busy[1]), 32'd1);
        wait_idle(1);

        // DIV=1: back-to-back words, second accepted in the done cycle.
        send(0, 16'h8001);
        send(0, 16'h7FFE);
        wait_idle(0);
        @(negedge clk);
        chk("b2b_accept_gap", acc_gap[0], 1);
        chk("b2b_done_gap", last_done[0] - prev_done[0], 34);

        // DIV=3: reset in the middle of SHIFT, then a clean transfer.
        send(2, 16'hC3A5);
        repeat (39) @(negedge clk);
        rst_n[2] = 1'b0;
        void'(exp_q[2].pop_back());
        @(negedge clk);
        chk("abort_outputs", {26'd0, sclk[2], sdata[2], latch[2], busy[2], done[2], load_ready[2]}, 32'h1);
        rst_n[2] = 1'b1;
        send(2, 16'h5A3C);
        wait_idle(2);

        // DIV=255: slowest legal clock.
        send(3, 16'h9C6B);
        wait_idle(3);

        // 1000 random words spread over DIV 1/2/3 instances running in parallel.
        cnt = '{0, 0, 0};
        for (int w = 0; w < 1000; w++) cnt[$urandom_range(0, 2)]++;
        fork
            stream(0, cnt[0]);
            stream(1, cnt[1]);
            stream(2, cnt[2]);
        join

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("queue_empty", exp_q[i].size(), 0);
            chk("done_width", dbl_err[i], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
